// File: rtl/t_sram_responder_pkg.sv
// Shared widths, response field offsets, FSM encoding and the word-count helper
// for the T-stream SRAM responder.
package t_sram_responder_pkg;

  localparam int unsigned BIT_P_GROUP = 20;
  localparam int unsigned T_PER_WORD  = 7;
  localparam int unsigned SRAM_WORD   = 4 + T_PER_WORD * BIT_P_GROUP;
  localparam int unsigned T_SIZE_LOG  = 10;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned MEM_W       = SRAM_WORD - 4;
  localparam int unsigned CNT_W       = 3;

  localparam int unsigned VALID_BIT = SRAM_WORD - 1;
  localparam int unsigned CNT_MSB   = SRAM_WORD - 2;
  localparam int unsigned CNT_LSB   = SRAM_WORD - 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Groups held by the word starting at base: min(7, T - base).
  function automatic logic [CNT_W-1:0] word_count(input logic [T_SIZE_LOG-1:0] t_size,
                                                   input logic [T_SIZE_LOG-1:0] base);
    logic [T_SIZE_LOG-1:0] rem;
    rem = t_size - base;
    if (rem >= T_SIZE_LOG'(T_PER_WORD)) return CNT_W'(T_PER_WORD);
    return CNT_W'(rem);
  endfunction

endpackage

// File: rtl/t_sram_responder_word_ptr.sv
// Word pointer over T: group base, word address and lap parity, wrapping to
// zero once the next base would reach T.
module t_word_ptr
  import t_sram_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [T_SIZE_LOG-1:0] t_size,
  output logic [T_SIZE_LOG-1:0] base,
  output logic [ADDR_W-1:0]     addr,
  output logic                  par,
  output logic                  wrap_c
);

  logic [T_SIZE_LOG:0] base_sum;

  assign base_sum = {1'b0, base} + (T_SIZE_LOG + 1)'(T_PER_WORD);
  assign wrap_c   = base_sum >= {1'b0, t_size};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
      addr <= '0;
      par  <= 1'b0;
    end else if (clr) begin
      base <= '0;
      addr <= '0;
      par  <= 1'b0;
    end else if (adv) begin
      if (wrap_c) begin
        base <= '0;
        addr <= '0;
        par  <= ~par;
      end else begin
        base <= base_sum[T_SIZE_LOG-1:0];
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/t_sram_responder.sv
// Responder for the T-stream word protocol: serves reads from a single-port
// SRAM, commits write-back words, and holds reads until the prior lap's word is back.
module t_sram_responder
  import t_sram_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_init,
  input  logic [T_SIZE_LOG-1:0] i_T_size,
  input  logic                  i_request,
  output logic [SRAM_WORD-1:0]  o_request_data,
  input  logic                  i_send,
  input  logic [SRAM_WORD-1:0]  i_send_data,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [MEM_W-1:0]      o_mem_wdata,
  input  logic [MEM_W-1:0]      i_mem_rdata,
  output logic                  o_busy
);

  state_e                state, state_nxt;
  logic [T_SIZE_LOG-1:0] t_size;
  logic                  wvalid;
  logic [MEM_W-1:0]      wbuf;
  logic                  rd_pend, rd_phase, cooldown, first_lap;
  logic [CNT_W-1:0]      rd_cnt;

  logic                  start_c, abort_c, issue_wr_c, issue_rd_c, hazard_ok_c;
  logic [T_SIZE_LOG-1:0] rd_base, wr_base_unused;
  logic [ADDR_W-1:0]     rd_addr, wr_addr;
  logic                  rd_par, wr_par, rd_wrap_c, wr_wrap_unused;
  logic                  send_hdr_unused;

  assign send_hdr_unused = ^i_send_data[SRAM_WORD-1:MEM_W];

  // A lap-L read of word k waits until lap L-1 has written word k back.
  assign hazard_ok_c = first_lap || (rd_par == wr_par) || (wr_addr > rd_addr);

  t_word_ptr u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_c),
    .adv    (issue_rd_c),
    .t_size (t_size),
    .base   (rd_base),
    .addr   (rd_addr),
    .par    (rd_par),
    .wrap_c (rd_wrap_c)
  );

  t_word_ptr u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_c),
    .adv    (issue_wr_c),
    .t_size (t_size),
    .base   (wr_base_unused),
    .addr   (wr_addr),
    .par    (wr_par),
    .wrap_c (wr_wrap_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and SRAM port arbitration; writes always win the port.
  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    abort_c    = 1'b0;
    issue_wr_c = 1'b0;
    issue_rd_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_RUN;
          start_c   = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_init) begin
          state_nxt = ST_IDLE;
          abort_c   = 1'b1;
        end else begin
          issue_wr_c = wvalid;
          issue_rd_c = !wvalid && i_request && !rd_pend && !cooldown && hazard_ok_c;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: SRAM command, write buffer and two-stage read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_request_data <= '0;
      o_mem_en       <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
      o_busy         <= 1'b0;
      t_size         <= '0;
      wvalid         <= 1'b0;
      wbuf           <= '0;
      rd_pend        <= 1'b0;
      rd_phase       <= 1'b0;
      cooldown       <= 1'b0;
      first_lap      <= 1'b0;
      rd_cnt         <= '0;
    end else begin
      o_mem_en       <= issue_wr_c || issue_rd_c;
      o_mem_we       <= issue_wr_c;
      o_busy         <= (state_nxt == ST_RUN);
      o_request_data <= '0;
      if (issue_wr_c) begin
        o_mem_addr  <= wr_addr;
        o_mem_wdata <= wbuf;
      end else if (issue_rd_c) begin
        o_mem_addr <= rd_addr;
      end

      if (start_c || abort_c) begin
        wvalid   <= 1'b0;
        rd_pend  <= 1'b0;
        rd_phase <= 1'b0;
        cooldown <= 1'b0;
        if (start_c) begin
          t_size    <= i_T_size;
          first_lap <= 1'b1;
        end
      end else if (state == ST_RUN) begin
        // The drain and a new send can share a cycle, so wvalid just follows i_send.
        wvalid   <= i_send;
        cooldown <= 1'b0;
        if (i_send) wbuf <= i_send_data[MEM_W-1:0];
        if (issue_rd_c) begin
          rd_pend  <= 1'b1;
          rd_phase <= 1'b0;
          rd_cnt   <= word_count(t_size, rd_base);
          if (rd_wrap_c) first_lap <= 1'b0;
        end else if (rd_pend && !rd_phase) begin
          rd_phase <= 1'b1;
        end else if (rd_pend) begin
          o_request_data[VALID_BIT]         <= 1'b1;
          o_request_data[CNT_MSB:CNT_LSB]   <= rd_cnt;
          o_request_data[CNT_LSB-1:0]       <= i_mem_rdata;
          rd_pend  <= 1'b0;
          rd_phase <= 1'b0;
          cooldown <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_t_sram_responder.sv
// Directed bench for t_sram_responder: per-cycle vector table against a
// behavioural single-port SRAM, plus a hand-written single-word (T = 7) sequence.
module tb_t_sram_responder;
  import t_sram_responder_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  i_start = 1'b0, i_init = 1'b0, i_request = 1'b0, i_send = 1'b0;
  logic [T_SIZE_LOG-1:0] i_T_size = '0;
  logic [SRAM_WORD-1:0]  i_send_data = '0;
  logic [SRAM_WORD-1:0]  o_request_data;
  logic                  o_mem_en, o_mem_we, o_busy;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [MEM_W-1:0]      o_mem_wdata;
  logic [MEM_W-1:0]      i_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  t_sram_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_init         (i_init),
    .i_T_size       (i_T_size),
    .i_request      (i_request),
    .o_request_data (o_request_data),
    .i_send         (i_send),
    .i_send_data    (i_send_data),
    .o_mem_en       (o_mem_en),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata),
    .o_busy         (o_busy)
  );

  // words[0] = zero, 1..3 = preloaded A0..A2, 4..8 = write-backs W0..W4
  logic [MEM_W-1:0] words [9];
  logic [MEM_W-1:0] mem [256];

  function automatic logic [MEM_W-1:0] mk(input int tag, input int k);
    logic [MEM_W-1:0] w;
    w = '0;
    for (int j = 0; j < int'(T_PER_WORD); j++)
      w[j*BIT_P_GROUP +: BIT_P_GROUP] = {12'(tag * 256 + k * 16), 4'(j), 4'(k)};
    return w;
  endfunction

  // Single-port SRAM: read data appears one cycle after the enable is sampled.
  always @(posedge clk) begin
    if (!rst_n) begin
      i_mem_rdata <= '0;
      for (int k = 0; k < 3; k++) mem[k] <= words[k+1];
    end else if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata <= mem[o_mem_addr];
    end
  end

  typedef struct {
    bit st; bit ini; int t; bit rq; int sd;
    bit ev; int cnt; int ed;
    bit en; bit we; int ad; int wd;
    bit bsy;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit st, input bit ini, input int t, input bit rq, input int sd,
                     input bit ev, input int cnt, input int ed,
                     input bit en, input bit we, input int ad, input int wd, input bit bsy);
    vec_t v;
    v.st = st; v.ini = ini; v.t = t; v.rq = rq; v.sd = sd;
    v.ev = ev; v.cnt = cnt; v.ed = ed;
    v.en = en; v.we = we; v.ad = ad; v.wd = wd; v.bsy = bsy;
    vq.push_back(v);
  endtask

  task automatic idle(input bit rq);
    add(0, 0, 20, rq, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic rd(input int ad);
    add(0, 0, 20, 1, 0, 0, 0, 0, 1, 0, ad, 0, 1);
  endtask
  task automatic rsp(input bit rq, input int cnt, input int ed);
    add(0, 0, 20, rq, 0, 1, cnt, ed, 0, 0, 0, 0, 1);
  endtask
  task automatic wr(input int sd, input int ad, input int wd);
    add(0, 0, 20, 1, sd, 0, 0, 0, 1, 1, ad, wd, 1);
  endtask

  task automatic chk(input string name, input int row, input logic [SRAM_WORD-1:0] got,
                     input logic [SRAM_WORD-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (row %0d): got %h want %h", name, row, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [SRAM_WORD-1:0] exp;
    words[0] = '0;
    for (int k = 0; k < 3; k++) words[k+1] = mk(10, k);
    for (int k = 0; k < 5; k++) words[k+4] = mk(11, k);

    // T = 20, lap 0: A0/A1/A2, with an i_start in RUN that must be ignored
    add(1, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(0); idle(1); rsp(1, 7, 1);
    add(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(1); idle(1); rsp(1, 7, 2); idle(1);
    rd(2); idle(1); rsp(1, 6, 3); idle(1);
    // lap 1: hazard stall until W0 is written back
    idle(1); idle(1); idle(1);
    add(0, 0, 20, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
    wr(0, 0, 4); rd(0); idle(1); rsp(1, 7, 4); idle(0);
    // three back-to-back sends, writes hold off an eligible read
    add(0, 0, 20, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    wr(6, 1, 5); wr(7, 2, 6); wr(0, 0, 7);
    rd(1); idle(1); rsp(1, 7, 5); idle(1);
    rd(2); idle(1); rsp(1, 6, 6); idle(1);
    rd(0); idle(0); rsp(0, 7, 7);
    add(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T = 14: two full words
    add(1, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(0); idle(1); rsp(1, 7, 7); idle(1);
    rd(1); idle(0); rsp(0, 7, 5);
    add(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // T = 3: one word at addr 0, lap 1 waits for its write-back
    add(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(0); idle(1); rsp(1, 3, 7); idle(1);
    add(0, 0, 20, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1);
    wr(0, 0, 8); rd(0); idle(0); rsp(0, 3, 8);
    add(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // abort with a read in flight (i_init beats i_start), then restart
    add(1, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(0);
    add(1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rd(0); idle(0); rsp(0, 7, 8); idle(0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", -1, o_request_data, '0);
    chk("reset_mem", -1, SRAM_WORD'({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}), '0);
    chk("reset_busy", -1, SRAM_WORD'(o_busy), '0);
    rst_n = 1'b1;

    for (int r = 0; r < vq.size(); r++) begin
      i_start     = vq[r].st;
      i_init      = vq[r].ini;
      i_T_size    = T_SIZE_LOG'(vq[r].t);
      i_request   = vq[r].rq;
      i_send      = (vq[r].sd != 0);
      i_send_data = {4'hF, words[vq[r].sd]};
      tick();
      exp = vq[r].ev ? {1'b1, CNT_W'(vq[r].cnt), words[vq[r].ed]} : '0;
      chk("resp", r, o_request_data, exp);
      chk("mem_en", r, SRAM_WORD'(o_mem_en), SRAM_WORD'(vq[r].en));
      chk("busy", r, SRAM_WORD'(o_busy), SRAM_WORD'(vq[r].bsy));
      if (vq[r].en)
        chk("mem_we_addr", r, SRAM_WORD'({o_mem_we, o_mem_addr}),
            SRAM_WORD'({vq[r].we, ADDR_W'(vq[r].ad)}));
      if (vq[r].en && vq[r].we)
        chk("mem_wdata", r, SRAM_WORD'(o_mem_wdata), SRAM_WORD'(words[vq[r].wd]));
    end

    // T = 7: exactly one full word; measure latency with a bounded wait
    i_start = 1'b0; i_send = 1'b0; i_request = 1'b0;
    i_init = 1'b1;
    tick();
    i_init = 1'b0; i_start = 1'b1; i_T_size = T_SIZE_LOG'(7);
    tick();
    i_start = 1'b0; i_request = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_request_data[VALID_BIT] && n < 10);
    chk("t7_latency", 100, SRAM_WORD'(n), SRAM_WORD'(3));
    chk("t7_resp", 100, o_request_data, {1'b1, 3'd7, words[8]});
    // second lap on the single word stalls with no write-back
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t7_stall_resp", 101 + k, o_request_data, '0);
      chk("t7_stall_en", 101 + k, SRAM_WORD'(o_mem_en), '0);
    end
    i_request = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t_sram_responder.md
Name: t_sram_responder

Overview:
- Responder end of the T-stream word protocol used by the data processor.
- Serves read requests by returning 7-group SRAM words, tagged with a valid bit and group count.
- Accepts write-back words carrying updated t/v/f groups and commits them to a single-port SRAM.
- Sits between the data processor and the SRAM macro. Enforces read-after-write ordering between successive passes over T.

Parameters:
BIT_P_GROUP, 20, bits per packed t/v/f group
T_PER_WORD, 7, groups per SRAM word (fixed 7; count field is 3 bits)
SRAM_WORD, 144, word width = 4 + T_PER_WORD*BIT_P_GROUP
T_SIZE_LOG, 10, width of T length and group offsets
ADDR_W, 8, SRAM word address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
i_start  in  1  one-cycle pulse: latch i_T_size, clear pointers, enter RUN
i_init  in  1  one-cycle pulse: abort, return to IDLE
i_T_size  in  T_SIZE_LOG  number of T groups (1..2^T_SIZE_LOG-1)
i_request  in  1  consumer wants the next word (level)
o_request_data  out  SRAM_WORD  [W-1] valid, [W-2:W-4] group count 1..7, [W-5:0] groups MSB-first
i_send  in  1  write-back word valid (one cycle)
i_send_data  in  SRAM_WORD  write-back word; only [W-5:0] stored
o_mem_en  out  1  SRAM access enable
o_mem_we  out  1  1 = write, 0 = read
o_mem_addr  out  ADDR_W  word address
o_mem_wdata  out  SRAM_WORD-4  write data
i_mem_rdata  in  SRAM_WORD-4  read data, valid one cycle after read enable
o_busy  out  1  high in RUN

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all pointers, flags and buffers cleared.
- FSM states:
  - IDLE: i_start -> RUN. Latches T, rd/wr base = 0, rd/wr addr = 0, rd_par = wr_par = 0, first_lap = 1.
  - RUN: i_init -> IDLE next cycle. Pending read and write buffer are discarded; o_request_data forced 0. i_start is ignored in RUN. i_init has priority over i_start.
- Write buffer (1 entry):
  - i_send captures i_send_data[W-5:0] into wbuf and sets wvalid.
  - Any cycle with wvalid: issue write (en = 1, we = 1, addr = wr_addr), clear wvalid, advance the write pointer.
  - i_send in the same cycle as the drain reloads wbuf, so there is no loss at one send per cycle.
  - Writes always win the SRAM port.
- Write pointer advance:
  - wr_base += 7 and wr_addr += 1.
  - If the old wr_base + 7 >= T: wr_base = 0, wr_addr = 0, toggle wr_par.
- Read issue: requires all of RUN, i_request, no write this cycle, rd_pend = 0, cooldown = 0, and the hazard check passes.
  - Issue drives en = 1, we = 0, addr = rd_addr; sets rd_pend.
  - Captured count = min(7, T - rd_base).
  - Then advance the read pointer as for writes (rd_base/rd_addr/rd_par). On wrap, clear first_lap.
- Hazard check:
  - Passes if first_lap = 1, or rd_par == wr_par, or wr_addr > rd_addr.
  - Meaning: word k of pass L >= 1 is read only after word k of pass L-1 has been written back.
- Response:
  - Cycle after issue: latch {1, count, i_mem_rdata} into o_request_data for exactly one cycle, then output 0.
  - Read latency is 2 cycles from the i_request cycle that issues.
  - Clear rd_pend; set cooldown for 1 cycle, during which i_request is ignored (absorbs the consumer's stale registered request).
- Boundaries:
  - T mod 7 = 0: last word count = 7.
  - T <= 7: a single word at addr 0, wrapping every access.
  - A stall on the hazard check holds the request with no output; the read proceeds on the cycle after the blocking write.

Decomposition:
- Shared package / `define header:
  - BIT_P_GROUP, T_PER_WORD, SRAM_WORD
  - field offsets: VALID_BIT = W-1, CNT_MSB = W-2, CNT_LSB = W-4
  - FSM state encodings IDLE/RUN
- Sub-module t_word_ptr: base/addr/parity advance-and-wrap given T. Instantiated twice (read and write).

Test Plan:
- Reset with T = 20 -> all outputs 0, o_busy = 0.
- i_start, T = 20, preloaded words A0..A2, i_request held -> responses A0 (cnt 7), A1 (cnt 7), A2 (cnt 6), each 2 cycles after issue with 1 idle cooldown cycle; rd_addr wraps to 0.
- Second lap, i_request held, no sends -> no output (hazard). Send W0 -> write at addr 0 next cycle, read of addr 0 the following cycle, response = W0 data with cnt 7.
- i_send and read-eligible request in the same cycle -> write issued first, read one cycle later; no dropped send over 3 back-to-back sends.
- T = 14 -> two words, both cnt 7. T = 3 -> one word, cnt 3, addr always 0.
- i_init asserted while rd_pend -> o_request_data stays 0, FSM IDLE, subsequent i_start restarts at addr 0 with first_lap = 1.
